// File: rtl/ysyx_22050598_trap_ctrl_pkg.sv
// Shared definitions for the ysyx_22050598 trap controller.
//   - trap_state_e   : trap/return sequencer states
//   - MSTATUS_*      : mstatus bit positions (MIE, MPIE, MPP)
//   - DEF_*_CAUSE    : default mcause values for ecall and machine timer irq
package ysyx_22050598_trap_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SAVE  = 2'd1,
    ST_RET   = 2'd2,
    ST_REDIR = 2'd3
  } trap_state_e;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [63:0] DEF_ECALL_CAUSE = 64'h0000_0000_0000_000b;
  localparam logic [63:0] DEF_TIMER_CAUSE = 64'h8000_0000_0000_0007;

endpackage

// File: rtl/ysyx_22050598_trap_mstatus_upd.sv
// Combinational mstatus rewrite for trap entry and mret.
// Ports:
//   mstatus_i       : current mstatus
//   trap_mstatus_o  : MPIE<=MIE, MIE<=0, MPP<=2'b11
//   ret_mstatus_o   : MIE<=MPIE, MPIE<=1, MPP<=2'b00
module ysyx_22050598_trap_mstatus_upd
  import ysyx_22050598_trap_ctrl_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] mstatus_i,
  output logic [XLEN-1:0] trap_mstatus_o,
  output logic [XLEN-1:0] ret_mstatus_o
);

  always_comb begin
    trap_mstatus_o                               = mstatus_i;
    trap_mstatus_o[MSTATUS_MPIE]                 = mstatus_i[MSTATUS_MIE];
    trap_mstatus_o[MSTATUS_MIE]                  = 1'b0;
    trap_mstatus_o[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

  always_comb begin
    ret_mstatus_o                               = mstatus_i;
    ret_mstatus_o[MSTATUS_MIE]                  = mstatus_i[MSTATUS_MPIE];
    ret_mstatus_o[MSTATUS_MPIE]                 = 1'b1;
    ret_mstatus_o[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b00;
  end

endmodule

// File: rtl/ysyx_22050598_trap_ctrl.sv
// Machine-mode trap / mret sequencer.
// Detects ecall, mret and (optionally) the machine timer interrupt on the EX
// instruction, writes mepc/mcause/mstatus, then requests a fetch redirect to
// mtvec (trap) or mepc (return) and flushes on the redirect handshake.
// Optional feature: define YSYX_22050598_TIMER_IRQ_EN to take timer interrupts;
// otherwise timer_irq_i is ignored and TIMER_CAUSE is never produced.
// Ports:
//   clk, rst                        : clock, asynchronous active-low reset
//   ex_valid_i/ex_inst_is_ecall_i/ex_inst_is_mret_i/ex_pc_i : EX instruction
//   mstatus_i, mtvec_i, mepc_i      : current CSR values
//   timer_irq_i                     : level machine timer interrupt
//   *_we_o / *_wdata_o              : one-cycle CSR write strobes and data
//   stall_o                         : freeze IF/ID/EX during sequencing
//   redir_valid_o/redir_pc_o/redir_ready_i : fetch redirect handshake
//   flush_o                         : pipeline flush on redirect handshake
module ysyx_22050598_trap_ctrl
  import ysyx_22050598_trap_ctrl_pkg::*;
#(
  parameter int              XLEN        = 64,
  parameter logic [XLEN-1:0] ECALL_CAUSE = XLEN'(DEF_ECALL_CAUSE),
  parameter logic [XLEN-1:0] TIMER_CAUSE = XLEN'(DEF_TIMER_CAUSE)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid_i,
  input  logic            ex_inst_is_ecall_i,
  input  logic            ex_inst_is_mret_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] mstatus_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic            timer_irq_i,
  output logic            mstatus_we_o,
  output logic            mepc_we_o,
  output logic            mcause_we_o,
  output logic [XLEN-1:0] mstatus_wdata_o,
  output logic [XLEN-1:0] mepc_wdata_o,
  output logic [XLEN-1:0] mcause_wdata_o,
  output logic            stall_o,
  output logic            redir_valid_o,
  output logic [XLEN-1:0] redir_pc_o,
  input  logic            redir_ready_i,
  output logic            flush_o
);

  trap_state_e     state;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] cause_q;
  logic [XLEN-1:0] target_q;

  logic            irq_take;
  logic            trap_take;
  logic            ret_take;
  logic [XLEN-1:0] trap_mstatus;
  logic [XLEN-1:0] ret_mstatus;
  logic [1:0]      unused_mtvec_lo;

`ifdef YSYX_22050598_TIMER_IRQ_EN
  assign irq_take = timer_irq_i & mstatus_i[MSTATUS_MIE];
`else
  logic unused_timer_irq;
  assign unused_timer_irq = timer_irq_i;
  assign irq_take         = 1'b0;
`endif

  // Interrupt beats ecall, and any trap beats mret (ecall+mret acts as ecall).
  assign trap_take = ex_valid_i & (ex_inst_is_ecall_i | irq_take);
  assign ret_take  = ex_valid_i & ex_inst_is_mret_i & ~trap_take;

  // Vector mode bits are ignored: always direct mode.
  assign unused_mtvec_lo = mtvec_i[1:0];

  ysyx_22050598_trap_mstatus_upd #(
    .XLEN (XLEN)
  ) u_mstatus_upd (
    .mstatus_i      (mstatus_i),
    .trap_mstatus_o (trap_mstatus),
    .ret_mstatus_o  (ret_mstatus)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      pc_q     <= '0;
      cause_q  <= '0;
      target_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (trap_take || ret_take) begin
            state   <= trap_take ? ST_SAVE : ST_RET;
            pc_q    <= ex_pc_i;
            cause_q <= irq_take ? TIMER_CAUSE : ECALL_CAUSE;
          end
        end
        ST_SAVE: begin
          state    <= ST_REDIR;
          target_q <= {mtvec_i[XLEN-1:2], 2'b00};
        end
        ST_RET: begin
          state    <= ST_REDIR;
          target_q <= mepc_i;
        end
        ST_REDIR: begin
          if (redir_ready_i) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic in_idle, in_save, in_ret, in_redir;
  assign in_idle  = (state == ST_IDLE);
  assign in_save  = (state == ST_SAVE);
  assign in_ret   = (state == ST_RET);
  assign in_redir = (state == ST_REDIR);

  assign mstatus_we_o    = in_save | in_ret;
  assign mepc_we_o       = in_save;
  assign mcause_we_o     = in_save;
  assign mstatus_wdata_o = in_save ? trap_mstatus : (in_ret ? ret_mstatus : '0);
  assign mepc_wdata_o    = in_save ? pc_q    : '0;
  assign mcause_wdata_o  = in_save ? cause_q : '0;

  // Stall is asserted in the detect cycle already; gated by rst so every
  // output reads 0 while reset is held, even with a trap on the EX inputs.
  assign stall_o       = rst & (~in_idle | trap_take | ret_take);
  assign redir_valid_o = in_redir;
  assign redir_pc_o    = in_redir ? target_q : '0;
  assign flush_o       = in_redir & redir_ready_i;

endmodule

// File: tb/tb_ysyx_22050598_trap_ctrl.sv
module tb_ysyx_22050598_trap_ctrl;

`ifdef YSYX_22050598_TIMER_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif
  localparam logic [63:0] ECALL_C = 64'h0b;
  localparam logic [63:0] TIMER_C = 64'h8000_0000_0000_0007;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0, ex_ecall = 1'b0, ex_mret = 1'b0;
  logic [63:0] ex_pc = '0, mstatus = '0, mtvec = '0, mepc = '0;
  logic        timer_irq = 1'b0, redir_ready = 1'b0;
  logic        mstatus_we, mepc_we, mcause_we, stall, redir_valid, flush;
  logic [63:0] mstatus_wdata, mepc_wdata, mcause_wdata, redir_pc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ysyx_22050598_trap_ctrl #(.XLEN(64)) dut (
    .clk                (clk),
    .rst                (rst),
    .ex_valid_i         (ex_valid),
    .ex_inst_is_ecall_i (ex_ecall),
    .ex_inst_is_mret_i  (ex_mret),
    .ex_pc_i            (ex_pc),
    .mstatus_i          (mstatus),
    .mtvec_i            (mtvec),
    .mepc_i             (mepc),
    .timer_irq_i        (timer_irq),
    .mstatus_we_o       (mstatus_we),
    .mepc_we_o          (mepc_we),
    .mcause_we_o        (mcause_we),
    .mstatus_wdata_o    (mstatus_wdata),
    .mepc_wdata_o       (mepc_wdata),
    .mcause_wdata_o     (mcause_wdata),
    .stall_o            (stall),
    .redir_valid_o      (redir_valid),
    .redir_pc_o         (redir_pc),
    .redir_ready_i      (redir_ready),
    .flush_o            (flush)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference rewrites of mstatus, straight from the privileged-spec rules.
  function automatic logic [63:0] ref_trap_ms(input logic [63:0] ms);
    logic [63:0] r;
    r = ms;
    r[7] = ms[3];
    r[3] = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  function automatic logic [63:0] ref_ret_ms(input logic [63:0] ms);
    logic [63:0] r;
    r = ms;
    r[3] = ms[7];
    r[7] = 1'b1;
    r[12:11] = 2'b00;
    return r;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic scramble_ex();
    ex_valid  = 1'($urandom);
    ex_ecall  = 1'($urandom);
    ex_mret   = 1'($urandom);
    ex_pc     = rnd64();
    timer_irq = 1'($urandom);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"}, {61'd0, mstatus_we, mepc_we, mcause_we}, 64'd0);
    chk({tag, "_ms_wd"}, mstatus_wdata, 64'd0);
    chk({tag, "_mepc_wd"}, mepc_wdata, 64'd0);
    chk({tag, "_mcause_wd"}, mcause_wdata, 64'd0);
    chk({tag, "_ctl"}, {61'd0, stall, redir_valid, flush}, 64'd0);
    chk({tag, "_rpc"}, redir_pc, 64'd0);
  endtask

  // One EX-stage event, followed through the whole trap/return sequence.
  task automatic run_txn(input logic v, input logic e, input logic m,
                         input logic [63:0] pc, input logic [63:0] ms,
                         input logic [63:0] tv, input logic [63:0] ep,
                         input logic irq, input int delay);
    logic        tk_irq, trap, ret;
    logic [63:0] cause, tgt;
    tk_irq = IRQ_EN & irq & ms[3];
    trap   = v & (e | tk_irq);
    ret    = v & m & ~trap;
    cause  = tk_irq ? TIMER_C : ECALL_C;
    tgt    = trap ? {tv[63:2], 2'b00} : ep;

    @(negedge clk);
    ex_valid = v; ex_ecall = e; ex_mret = m; ex_pc = pc;
    mstatus = ms; mtvec = tv; mepc = ep; timer_irq = irq;
    redir_ready = 1'($urandom);
    #1;
    chk("detect_stall", {63'd0, stall}, {63'd0, trap | ret});
    chk("detect_we", {61'd0, mstatus_we, mepc_we, mcause_we}, 64'd0);
    chk("detect_rv", {63'd0, redir_valid | flush}, 64'd0);
    if (!(trap | ret)) return;

    @(negedge clk);
    scramble_ex();
    #1;
    chk("csr_stall", {63'd0, stall}, 64'd1);
    chk("csr_ms_we", {63'd0, mstatus_we}, 64'd1);
    chk("csr_mepc_we", {63'd0, mepc_we}, {63'd0, trap});
    chk("csr_mcause_we", {63'd0, mcause_we}, {63'd0, trap});
    chk("csr_ms_wd", mstatus_wdata, trap ? ref_trap_ms(ms) : ref_ret_ms(ms));
    chk("csr_mepc_wd", mepc_wdata, trap ? pc : 64'd0);
    chk("csr_mcause_wd", mcause_wdata, trap ? cause : 64'd0);
    chk("csr_rv", {63'd0, redir_valid | flush}, 64'd0);

    for (int i = 0; i <= delay; i++) begin
      @(negedge clk);
      scramble_ex();
      mstatus = rnd64(); mtvec = rnd64(); mepc = rnd64();
      redir_ready = (i == delay);
      #1;
      chk("redir_valid", {63'd0, redir_valid}, 64'd1);
      chk("redir_pc", redir_pc, tgt);
      chk("redir_stall", {63'd0, stall}, 64'd1);
      chk("redir_flush", {63'd0, flush}, {63'd0, i == delay});
      chk("redir_we", {61'd0, mstatus_we, mepc_we, mcause_we}, 64'd0);
    end

    @(negedge clk);
    ex_valid = 1'b0; redir_ready = 1'b0;
    #1;
    chk("back_idle", {62'd0, stall, redir_valid}, 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with a trap presented on the inputs.
    ex_valid = 1'b1; ex_ecall = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");
    ex_valid = 1'b0; ex_ecall = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // ecall, ready immediately: 3-cycle minimum latency.
    run_txn(1, 1, 0, 64'h8000_0010, 64'h0000_0000_0000_1808, 64'h8000_0101,
            64'h0, 0, 0);
    // mret from mstatus 0x80 -> 0x88, no mepc write.
    run_txn(1, 0, 1, 64'h8000_0020, 64'h80, 64'h8000_0100, 64'h8000_0014, 0, 0);
    // ecall + mret together is ecall.
    run_txn(1, 1, 1, 64'h8000_0030, 64'h0, 64'h8000_0200, 64'h8000_0044, 0, 1);
    // Timer irq with MIE=1 and with MIE=0, alongside an ecall.
    run_txn(1, 1, 0, 64'h8000_0040, 64'h8, 64'h8000_0300, 64'h0, 1, 0);
    run_txn(1, 1, 0, 64'h8000_0050, 64'h0, 64'h8000_0300, 64'h0, 1, 0);
    // Timer irq alone on a valid non-trapping instruction.
    run_txn(1, 0, 0, 64'h8000_0060, 64'h8, 64'h8000_0400, 64'h0, 1, 2);
    // Invalid EX instruction is ignored.
    run_txn(0, 1, 1, 64'h8000_0070, 64'h8, 64'h8000_0400, 64'h0, 1, 0);
    // Ready held low for 5 cycles in REDIR.
    run_txn(1, 1, 0, 64'h8000_0080, 64'h0, 64'h8000_0503, 64'h0, 0, 5);

    // Reset during REDIR abandons the sequence.
    @(negedge clk);
    ex_valid = 1'b1; ex_ecall = 1'b1; ex_pc = 64'h8000_0090; mtvec = 64'h8000_0600;
    @(negedge clk);
    ex_valid = 1'b0; ex_ecall = 1'b0;
    @(negedge clk);
    #1;
    chk("pre_rst_rv", {63'd0, redir_valid}, 64'd1);
    #2;
    rst = 1'b0; ex_valid = 1'b1; ex_ecall = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    #1;
    chk_all_zero("rst_held");
    @(negedge clk);
    ex_valid = 1'b0; ex_ecall = 1'b0; rst = 1'b1;
    #1;
    chk_all_zero("rst_release");
    run_txn(1, 0, 1, 64'h8000_00a0, 64'h80, 64'h0, 64'h8000_0014, 0, 0);

    // Randomized traffic.
    for (int n = 0; n < 200; n++) begin
      run_txn(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), rnd64(),
              rnd64(), rnd64(), rnd64(), 1'($urandom), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
